// File: rtl/i2s_tx_serializer_pkg.sv
// Shared definitions for the I2S transmit path: channel codes, FSM states, frame helpers.
package i2s_tx_serializer_pkg;

    localparam logic I2S_LEFT  = 1'b0;
    localparam logic I2S_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2
    } i2s_state_t;

    function automatic int frame_width(input int dw);
        return 2 * dw;
    endfunction

    // ws switches one bit before the channel it announces, hence the shifted window.
    function automatic logic ws_for_bit(input int idx, input int dw);
        return (idx >= dw - 1 && idx <= 2 * dw - 2) ? I2S_RIGHT : I2S_LEFT;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_sync_fifo.sv
// Generic single-clock FIFO; head entry is presented on pop_data while not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (level_reg == (AW + 1)'(DEPTH));
    assign empty    = (level_reg == '0);
    assign level    = level_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + (AW + 1)'(1);
                2'b01:   level_reg <= level_reg - (AW + 1)'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: buffers stereo frames, divides clk to sck and shifts frames out MSB first.
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [DIV_W-1:0]             clk_div,
    input  logic                         sample_valid,
    input  logic [2*DW-1:0]              sample_data,
    output logic                         sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         underrun,
    output logic                         busy,
    output logic                         i2s_sck,
    output logic                         i2s_ws,
    output logic                         i2s_sd
);
    localparam int FW = frame_width(DW);
    localparam int BW = $clog2(FW);
    localparam logic [BW-1:0] LAST_IDX = BW'(FW - 1);

    i2s_state_t       state_reg, state_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [BW-1:0]    bit_idx_reg, bit_idx_next;
    logic [FW-1:0]    shreg_reg, shreg_next;
    logic             sck_reg, sck_next;
    logic             ws_reg, ws_next;
    logic             sd_reg, sd_next;
    logic             underrun_reg, underrun_next;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_data;
    logic             div_tick;
    logic             fall_tick;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (sample_valid),
        .push_data (sample_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign div_tick  = (state_reg == ST_RUN) && (div_cnt_reg == clk_div);
    assign fall_tick = div_tick && sck_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            div_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            shreg_reg    <= '0;
            sck_reg      <= 1'b0;
            ws_reg       <= 1'b0;
            sd_reg       <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shreg_reg    <= shreg_next;
            sck_reg      <= sck_next;
            ws_reg       <= ws_next;
            sd_reg       <= sd_next;
            underrun_reg <= underrun_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shreg_next    = shreg_reg;
        sck_next      = sck_reg;
        ws_next       = ws_reg;
        sd_next       = sd_reg;
        underrun_next = 1'b0;
        fifo_pop      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                sck_next     = 1'b0;
                ws_next      = 1'b0;
                sd_next      = 1'b0;
                div_cnt_next = '0;
                bit_idx_next = '0;
                if (enable && !fifo_empty) begin
                    state_next = ST_START;
                end
            end
            ST_START: begin
                fifo_pop     = 1'b1;
                shreg_next   = fifo_data;
                sd_next      = fifo_data[FW-1];
                ws_next      = I2S_LEFT;
                sck_next     = 1'b0;
                bit_idx_next = '0;
                div_cnt_next = '0;
                state_next   = ST_RUN;
            end
            ST_RUN: begin
                if (div_tick) begin
                    div_cnt_next = '0;
                    sck_next     = !sck_reg;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_W'(1);
                end
                if (fall_tick) begin
                    if (bit_idx_reg != LAST_IDX) begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                        shreg_next   = shreg_reg << 1;
                        sd_next      = shreg_reg[FW-2];
                    end else if (!enable) begin
                        // Frame boundary with the run bit cleared: park, keep queued frames.
                        state_next   = ST_IDLE;
                        sd_next      = 1'b0;
                        bit_idx_next = '0;
                    end else if (!fifo_empty) begin
                        fifo_pop     = 1'b1;
                        shreg_next   = fifo_data;
                        sd_next      = fifo_data[FW-1];
                        bit_idx_next = '0;
                    end else begin
                        shreg_next    = '0;
                        sd_next       = 1'b0;
                        bit_idx_next  = '0;
                        underrun_next = 1'b1;
                    end
                    ws_next = ws_for_bit(int'(bit_idx_next), DW);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign sample_ready = !fifo_full;
    assign underrun     = underrun_reg;
    assign busy         = (state_reg == ST_START) || (state_reg == ST_RUN);
    assign i2s_sck      = sck_reg;
    assign i2s_ws       = ws_reg;
    assign i2s_sd       = sd_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: receiver-side capture on sck rises compared with queued frames.
module tb_i2s_tx_serializer;
    localparam int DW    = 16;
    localparam int FD    = 4;
    localparam int DIV_W = 32;
    localparam int FW    = 2 * DW;
    localparam int LW    = $clog2(FD) + 1;
    localparam int CAPN  = 4096;
    localparam int BOUND = 5000;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] clk_div;
    logic             sample_valid;
    logic [FW-1:0]    sample_data;
    logic             sample_ready;
    logic [LW-1:0]    fifo_level;
    logic             underrun;
    logic             busy;
    logic             i2s_sck;
    logic             i2s_ws;
    logic             i2s_sd;

    int total = 0;
    int bad   = 0;

    i2s_tx_serializer #(.DW(DW), .FIFO_DEPTH(FD), .DIV_W(DIV_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clk_div      (clk_div),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .busy         (busy),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd)
    );

    always #5 clk = ~clk;

    // Receiver view: latch ws/sd on every sck rise, log underrun pulses.
    int   cyc      = 0;
    int   cap_n    = 0;
    int   undr_cnt = 0;
    int   undr_cyc = 0;
    logic sck_prev = 1'b0;
    logic cap_sd  [CAPN];
    logic cap_ws  [CAPN];
    int   cap_cyc [CAPN];

    always @(negedge clk) begin
        cyc      <= cyc + 1;
        sck_prev <= i2s_sck;
        if (i2s_sck === 1'b1 && sck_prev === 1'b0 && cap_n < CAPN) begin
            cap_sd[cap_n]  <= i2s_sd;
            cap_ws[cap_n]  <= i2s_ws;
            cap_cyc[cap_n] <= cyc + 1;
            cap_n          <= cap_n + 1;
        end
        if (underrun === 1'b1) begin
            undr_cnt <= undr_cnt + 1;
            undr_cyc <= cyc + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] cap_word(input int start);
        logic [FW-1:0] w = '0;
        for (int i = 0; i < FW; i++) w[FW-1-i] = cap_sd[start+i];
        return w;
    endfunction

    function automatic logic [FW-1:0] cap_ws_word(input int start);
        logic [FW-1:0] w = '0;
        for (int i = 0; i < FW; i++) w[FW-1-i] = cap_ws[start+i];
        return w;
    endfunction

    // Expected ws per bit slot: right channel is announced from the left LSB onwards.
    function automatic logic [FW-1:0] exp_ws_word();
        logic [FW-1:0] w = '0;
        for (int b = 0; b < FW; b++) w[FW-1-b] = (b >= DW - 1) && (b != FW - 1);
        return w;
    endfunction

    function automatic int gap_min(input int from, input int to);
        int m = 1 << 30;
        for (int i = from + 1; i < to; i++)
            if (cap_cyc[i] - cap_cyc[i-1] < m) m = cap_cyc[i] - cap_cyc[i-1];
        return m;
    endfunction

    function automatic int gap_max(input int from, input int to);
        int m = 0;
        for (int i = from + 1; i < to; i++)
            if (cap_cyc[i] - cap_cyc[i-1] > m) m = cap_cyc[i] - cap_cyc[i-1];
        return m;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        sample_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic push_one(input logic [FW-1:0] d, output bit ok);
        int n = 0;
        ok = 1'b1;
        while (sample_ready !== 1'b1) begin
            tick();
            n++;
            if (n > BOUND) begin
                ok = 1'b0;
                return;
            end
        end
        sample_data  = d;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    // Run until the last of nfr frames has started, then clear enable and wait for idle.
    task automatic run_frames(input int base, input int nfr, output bit ok);
        int n = 0;
        ok = 1'b1;
        enable = 1'b1;
        while (cap_n <= base + FW * (nfr - 1)) begin
            tick();
            n++;
            if (n > BOUND) begin
                ok = 1'b0;
                break;
            end
        end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0) begin
            tick();
            n++;
            if (n > BOUND) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (i2s_sck !== 1'b0) begin bad++; $display("FAIL reset_sck got=%b want=0", i2s_sck); end
        total++; if (i2s_ws !== 1'b0) begin bad++; $display("FAIL reset_ws got=%b want=0", i2s_ws); end
        total++; if (i2s_sd !== 1'b0) begin bad++; $display("FAIL reset_sd got=%b want=0", i2s_sd); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL reset_level got=%0d want=0", fifo_level); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", sample_ready); end
    endtask

    task automatic test_single_frame();
        logic [FW-1:0] d = 32'hA5A5_0F0F;
        int base, c0, u0, n;
        bit ok;
        do_reset();
        clk_div = 1;
        push_one(d, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_push got=timeout want=accepted"); end
        base = cap_n;
        u0 = undr_cnt;
        enable = 1'b1;
        tick();
        total++; if (i2s_sd !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_start got sd=%b busy=%b want sd=0 busy=1", i2s_sd, busy); end
        tick();
        c0 = cyc;
        total++; if (i2s_sd !== d[FW-1]) begin bad++; $display("FAIL single_latency got=%b want=%b", i2s_sd, d[FW-1]); end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin tick(); n++; end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b want=0", busy); end
        total++; if (cap_n - base != FW) begin bad++; $display("FAIL single_bits got=%0d want=%0d", cap_n - base, FW); end
        $display("frame single: want=%h got=%h ws=%h", d, cap_word(base), cap_ws_word(base));
        total++; if (cap_word(base) !== d) begin bad++; $display("FAIL single_sd got=%h want=%h", cap_word(base), d); end
        total++; if (cap_ws_word(base) !== exp_ws_word()) begin bad++; $display("FAIL single_ws got=%h want=%h", cap_ws_word(base), exp_ws_word()); end
        total++; if (cap_cyc[base] != c0 + 2) begin bad++; $display("FAIL single_first_rise got=%0d want=%0d", cap_cyc[base] - c0, 2); end
        total++; if (gap_min(base, base + FW) != 4 || gap_max(base, base + FW) != 4) begin
            bad++; $display("FAIL single_period got=%0d..%0d want=4", gap_min(base, base + FW), gap_max(base, base + FW));
        end
        total++; if (undr_cnt != u0) begin bad++; $display("FAIL single_underrun got=%0d want=0", undr_cnt - u0); end
        total++; if ({i2s_sck, i2s_ws, i2s_sd} !== 3'b000) begin bad++; $display("FAIL single_park got=%b want=000", {i2s_sck, i2s_ws, i2s_sd}); end
    endtask

    task automatic test_fifo_full();
        logic [FW-1:0] exp_q[$];
        int mlvl = 0;
        int base;
        bit ok;
        do_reset();
        clk_div = 1;
        for (int k = 0; k < 5; k++) begin
            sample_data  = $urandom;
            sample_valid = 1'b1;
            total++; if (sample_ready !== 1'(mlvl < FD)) begin bad++; $display("FAIL full_ready%0d got=%b want=%b", k, sample_ready, mlvl < FD); end
            if (mlvl < FD) begin
                exp_q.push_back(sample_data);
                mlvl++;
            end
            tick();
        end
        sample_valid = 1'b0;
        total++; if (fifo_level !== LW'(FD)) begin bad++; $display("FAIL full_level got=%0d want=%0d", fifo_level, FD); end
        base = cap_n;
        run_frames(base, exp_q.size(), ok);
        total++; if (!ok) begin bad++; $display("FAIL full_drain got=timeout want=idle"); end
        total++; if (cap_n - base != FW * exp_q.size()) begin bad++; $display("FAIL full_bits got=%0d want=%0d", cap_n - base, FW * exp_q.size()); end
        foreach (exp_q[f]) begin
            $display("frame full%0d: want=%h got=%h ws=%h", f, exp_q[f], cap_word(base + FW * f), cap_ws_word(base + FW * f));
            total++; if (cap_word(base + FW * f) !== exp_q[f] || cap_ws_word(base + FW * f) !== exp_ws_word()) begin
                bad++; $display("FAIL full_frame%0d got=%h want=%h", f, cap_word(base + FW * f), exp_q[f]);
            end
        end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL full_after got=%0d want=0", fifo_level); end
    endtask

    task automatic test_underrun();
        logic [FW-1:0] d;
        int base, u0, n;
        bit ok = 1'b1;
        do_reset();
        clk_div = 1;
        d = $urandom;
        push_one(d, ok);
        base = cap_n;
        u0 = undr_cnt;
        enable = 1'b1;
        n = 0;
        while ((undr_cnt == u0 || cap_n <= base + FW) && n < BOUND) begin tick(); n++; end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin tick(); n++; end
        total++; if (!ok || busy !== 1'b0) begin bad++; $display("FAIL underrun_run got busy=%b want=0", busy); end
        total++; if (cap_n - base != 2 * FW) begin bad++; $display("FAIL underrun_bits got=%0d want=%0d", cap_n - base, 2 * FW); end
        $display("frame data: want=%h got=%h", d, cap_word(base));
        total++; if (cap_word(base) !== d) begin bad++; $display("FAIL underrun_frame1 got=%h want=%h", cap_word(base), d); end
        $display("frame silence: want=%h got=%h ws=%h", 32'h0, cap_word(base + FW), cap_ws_word(base + FW));
        total++; if (cap_word(base + FW) !== '0) begin bad++; $display("FAIL underrun_silence got=%h want=0", cap_word(base + FW)); end
        total++; if (cap_ws_word(base + FW) !== exp_ws_word()) begin bad++; $display("FAIL underrun_ws got=%h want=%h", cap_ws_word(base + FW), exp_ws_word()); end
        total++; if (undr_cnt - u0 != 1) begin bad++; $display("FAIL underrun_width got=%0d want=1", undr_cnt - u0); end
        total++; if (!(undr_cyc > cap_cyc[base + FW - 1] && undr_cyc < cap_cyc[base + FW])) begin
            bad++; $display("FAIL underrun_when got=%0d want in (%0d,%0d)", undr_cyc, cap_cyc[base + FW - 1], cap_cyc[base + FW]);
        end
    endtask

    task automatic test_disable_mid();
        logic [FW-1:0] exp_q[$];
        logic [FW-1:0] d;
        int base, n;
        bit ok, all_ok = 1'b1;
        do_reset();
        clk_div = 1;
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            push_one(d, ok);
            all_ok &= ok;
            exp_q.push_back(d);
        end
        base = cap_n;
        enable = 1'b1;
        n = 0;
        while (cap_n < base + 6 && n < BOUND) begin tick(); n++; end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin tick(); n++; end
        total++; if (!all_ok || busy !== 1'b0) begin bad++; $display("FAIL disable_idle got busy=%b want=0", busy); end
        total++; if (cap_n - base != FW) begin bad++; $display("FAIL disable_bits got=%0d want=%0d", cap_n - base, FW); end
        $display("frame dis0: want=%h got=%h", exp_q[0], cap_word(base));
        total++; if (cap_word(base) !== exp_q[0]) begin bad++; $display("FAIL disable_frame0 got=%h want=%h", cap_word(base), exp_q[0]); end
        total++; if ({i2s_sck, i2s_ws, i2s_sd} !== 3'b000) begin bad++; $display("FAIL disable_park got=%b want=000", {i2s_sck, i2s_ws, i2s_sd}); end
        total++; if (fifo_level !== LW'(2)) begin bad++; $display("FAIL disable_level got=%0d want=2", fifo_level); end
        base = cap_n;
        run_frames(base, 2, ok);
        total++; if (!ok) begin bad++; $display("FAIL disable_resume got=timeout want=idle"); end
        for (int f = 1; f < 3; f++) begin
            $display("frame dis%0d: want=%h got=%h", f, exp_q[f], cap_word(base + FW * (f - 1)));
            total++; if (cap_word(base + FW * (f - 1)) !== exp_q[f]) begin
                bad++; $display("FAIL disable_frame%0d got=%h want=%h", f, cap_word(base + FW * (f - 1)), exp_q[f]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int base, n;
        bit ok, all_ok = 1'b1;
        do_reset();
        clk_div = 1;
        for (int k = 0; k < 3; k++) begin
            push_one($urandom, ok);
            all_ok &= ok;
        end
        base = cap_n;
        enable = 1'b1;
        n = 0;
        while (cap_n < base + 3 && n < BOUND) begin tick(); n++; end
        total++; if (!all_ok || busy !== 1'b1) begin bad++; $display("FAIL rstmid_running got busy=%b want=1", busy); end
        enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({i2s_sck, i2s_ws, i2s_sd} !== 3'b000) begin bad++; $display("FAIL rstmid_lines got=%b want=000", {i2s_sck, i2s_ws, i2s_sd}); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL rstmid_level got=%0d want=0", fifo_level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b want=1", sample_ready); end
        tick();
        tick();
        total++; if (busy !== 1'b0 || i2s_sck !== 1'b0) begin bad++; $display("FAIL rstmid_stays got busy=%b sck=%b want 0 0", busy, i2s_sck); end
    endtask

    task automatic test_back_to_back();
        localparam int NP = 6;
        logic [FW-1:0] exp_q[$];
        logic [FW-1:0] d;
        logic [LW-1:0] lvl_before;
        int base, u0, n, prev_n, pushed, nfr;
        bit ok, all_ok = 1'b1;
        do_reset();
        clk_div = 0;
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            push_one(d, ok);
            all_ok &= ok;
            exp_q.push_back(d);
        end
        nfr = 2 + NP;
        base = cap_n;
        u0 = undr_cnt;
        prev_n = cap_n;
        pushed = 0;
        n = 0;
        enable = 1'b1;
        while (cap_n <= base + FW * (nfr - 1)) begin
            tick();
            n++;
            if (n > BOUND) begin
                all_ok = 1'b0;
                break;
            end
            // Last bit of a frame just seen: the next edge pops, so push on that same edge.
            if (cap_n != prev_n && cap_n > base && ((cap_n - base) % FW) == 0 && pushed < NP) begin
                d = $urandom;
                lvl_before = fifo_level;
                sample_data = d;
                sample_valid = 1'b1;
                total++; if (sample_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b want=1", pushed, sample_ready); end
                tick();
                sample_valid = 1'b0;
                exp_q.push_back(d);
                pushed++;
                total++; if (fifo_level !== lvl_before) begin bad++; $display("FAIL b2b_level%0d got=%0d want=%0d", pushed, fifo_level, lvl_before); end
            end
            prev_n = cap_n;
        end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin tick(); n++; end
        total++; if (!all_ok || busy !== 1'b0) begin bad++; $display("FAIL b2b_run got busy=%b want=0", busy); end
        total++; if (cap_n - base != FW * nfr) begin bad++; $display("FAIL b2b_bits got=%0d want=%0d", cap_n - base, FW * nfr); end
        foreach (exp_q[f]) begin
            $display("frame b2b%0d: want=%h got=%h", f, exp_q[f], cap_word(base + FW * f));
            total++; if (cap_word(base + FW * f) !== exp_q[f] || cap_ws_word(base + FW * f) !== exp_ws_word()) begin
                bad++; $display("FAIL b2b_frame%0d got=%h want=%h", f, cap_word(base + FW * f), exp_q[f]);
            end
        end
        total++; if (gap_min(base, cap_n) != 2 || gap_max(base, cap_n) != 2) begin
            bad++; $display("FAIL b2b_period got=%0d..%0d want=2", gap_min(base, cap_n), gap_max(base, cap_n));
        end
        total++; if (undr_cnt != u0) begin bad++; $display("FAIL b2b_underrun got=%0d want=0", undr_cnt - u0); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL b2b_level_end got=%0d want=0", fifo_level); end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        clk_div      = 1;
        test_reset();
        test_single_frame();
        test_fifo_full();
        test_underrun();
        test_disable_mid();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
